// File: rtl/axi4m_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4m_rd_arb_pkg
// Purpose  : Shared definitions for the AXI4 read-command arbiter: FSM state
//            encoding, read-command field positions and the default
//            outstanding-burst limit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi4m_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  // Read-command field positions
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 33;
  localparam int ID_LSB   = 34;
  localparam int ID_MSB   = 35;
  localparam int REM_LSB  = 36;
  localparam int REM_MSB  = 41;
  localparam int LEN_LSB  = 42;
  localparam int LEN_MSB  = 49;

  // Limit used when reg_max_ost_cfg is programmed to 0
  localparam int OST_LIM_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/axi4m_rd_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb4
// Purpose  : Combinational 4-way round-robin picker. Searches upward from
//            last_i+1 (mod 4) and returns the first requesting index one-hot.
// Ports    : req_i  [3:0] request vector
//            last_i [1:0] index of the previous winner
//            gnt_o  [3:0] one-hot grant (all-zero when req_i is zero)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o
);

  // Walk from the farthest candidate (last_i itself) to the nearest
  // (last_i+1); the final overwrite leaves the highest-priority requester.
  always_comb begin
    gnt_o = '0;
    for (int k = 4; k >= 1; k--) begin
      logic [1:0] idx;
      idx = last_i + 2'(k);
      if (req_i[idx]) gnt_o = 4'b0001 << idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4m_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : axi4m_rd_arb
// Purpose  : Round-robin arbiter for four AXI4 read-command requesters with
//            per-requester outstanding-burst limiting, a registered write
//            port into a downstream command FIFO and a RUN/DRAIN/IDLE
//            controller for clean shutdown.
// Ports    : aclk, areset        clock, synchronous active-high reset
//            req_vld/req_data    requester commands (req_data 4 x CMD_W)
//            req_rdy             combinational one-hot accept
//            rcmd_ff_*           downstream FIFO full / write strobe / data
//            rtn_vld/last/id     accepted read-data beats (completion)
//            reg_arb_en/mask/max_ost_cfg  run control and eligibility config
//            arb_idle, ost_cnt, reg_ost_err  status
// Revision : 1.0 - initial release
// ============================================================================
module axi4m_rd_arb
  import axi4m_rd_arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int CMD_W   = 72,
  parameter int OST_W   = 5
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [REQ_NUM-1:0]       req_vld,
  input  logic [REQ_NUM*CMD_W-1:0] req_data,
  output logic [REQ_NUM-1:0]       req_rdy,
  input  logic                     rcmd_ff_full,
  output logic                     rcmd_ff_wen,
  output logic [CMD_W-1:0]         rcmd_ff_wdata,
  input  logic                     rtn_vld,
  input  logic                     rtn_last,
  input  logic [3:0]               rtn_id,
  input  logic                     reg_arb_en,
  input  logic [REQ_NUM-1:0]       reg_arb_mask,
  input  logic [3:0]               reg_max_ost_cfg,
  output logic                     arb_idle,
  output logic [REQ_NUM*OST_W-1:0] ost_cnt,
  output logic [REQ_NUM-1:0]       reg_ost_err
);

  state_e             state_q, state_d;
  logic [1:0]         last_q;
  logic [OST_W-1:0]   cnt_q [REQ_NUM];
  logic [OST_W-1:0]   cnt_d [REQ_NUM];
  logic [REQ_NUM-1:0] err_q, err_d;
  logic               wen_q;
  logic [CMD_W-1:0]   wdata_q;

  logic [OST_W-1:0]   lim;
  logic [REQ_NUM-1:0] elig, gnt, inc, dec;
  logic               grant_en, any_grant, all_zero_d;
  logic [1:0]         win_idx;
  logic [CMD_W-1:0]   win_cmd;

  // Upper rid bits carry no requester information
  logic unused_rtn_id_hi;
  assign unused_rtn_id_hi = ^rtn_id[3:2];

  assign lim = (reg_max_ost_cfg == 4'd0) ? OST_W'(OST_LIM_DEF) : OST_W'(reg_max_ost_cfg);

  for (genvar n = 0; n < REQ_NUM; n++) begin : g_req
    assign elig[n] = req_vld[n] & ~reg_arb_mask[n] & (cnt_q[n] < lim);
    assign inc[n]  = req_rdy[n];
    assign dec[n]  = rtn_vld & rtn_last & (rtn_id[1:0] == 2'(n));
    assign ost_cnt[n*OST_W +: OST_W] = cnt_q[n];
  end

  rr_arb4 u_rr (
    .req_i  (elig),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign grant_en  = (state_q == ST_RUN) & ~rcmd_ff_full & ~areset;
  assign req_rdy   = grant_en ? gnt : '0;
  assign any_grant = |req_rdy;

  always_comb begin
    win_idx = '0;
    for (int n = 0; n < REQ_NUM; n++) begin
      if (gnt[n]) win_idx = 2'(n);
    end
  end

  // Winner's command with the id field replaced by the requester index
  always_comb begin
    win_cmd = req_data[int'(win_idx)*CMD_W +: CMD_W];
    win_cmd[ID_MSB:ID_LSB] = win_idx;
  end

  // Outstanding counters: a same-cycle issue and completion cancel out;
  // a completion with nothing outstanding saturates and flags an error.
  always_comb begin
    all_zero_d = 1'b1;
    for (int n = 0; n < REQ_NUM; n++) begin
      cnt_d[n] = cnt_q[n];
      err_d[n] = err_q[n];
      if (inc[n] && !dec[n]) begin
        cnt_d[n] = cnt_q[n] + OST_W'(1);
      end else if (dec[n] && !inc[n]) begin
        if (cnt_q[n] == '0) err_d[n] = 1'b1;
        else                cnt_d[n] = cnt_q[n] - OST_W'(1);
      end
      if (cnt_d[n] != '0) all_zero_d = 1'b0;
    end
  end

  // DRAIN issues no grants, so the only possible pending write is the strobe
  // already on the bus this cycle; checking next-cycle counts lets IDLE be
  // reached the cycle after the last completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (!reg_arb_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (reg_arb_en)      state_d = ST_RUN;
        else if (all_zero_d) state_d = ST_IDLE;
      end
      ST_IDLE:  if (reg_arb_en) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      err_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      for (int n = 0; n < REQ_NUM; n++) cnt_q[n] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wen_q   <= any_grant;
      for (int n = 0; n < REQ_NUM; n++) cnt_q[n] <= cnt_d[n];
      if (any_grant) begin
        last_q  <= win_idx;
        wdata_q <= win_cmd;
      end
    end
  end

  assign rcmd_ff_wen   = wen_q;
  assign rcmd_ff_wdata = wdata_q;
  assign reg_ost_err   = err_q;
  assign arb_idle      = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi4m_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4m_rd_arb
// Purpose  : Self-checking bench for axi4m_rd_arb: a per-cycle behavioural
//            model of grants, counters and run state plus directed
//            scenarios with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4m_rd_arb;

  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   req_vld;
  logic [287:0] req_data;
  logic [3:0]   req_rdy;
  logic         rcmd_ff_full;
  logic         rcmd_ff_wen;
  logic [71:0]  rcmd_ff_wdata;
  logic         rtn_vld, rtn_last;
  logic [3:0]   rtn_id;
  logic         reg_arb_en;
  logic [3:0]   reg_arb_mask, reg_max_ost_cfg;
  logic         arb_idle;
  logic [19:0]  ost_cnt;
  logic [3:0]   reg_ost_err;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4m_rd_arb dut (
    .aclk            (aclk),
    .areset          (areset),
    .req_vld         (req_vld),
    .req_data        (req_data),
    .req_rdy         (req_rdy),
    .rcmd_ff_full    (rcmd_ff_full),
    .rcmd_ff_wen     (rcmd_ff_wen),
    .rcmd_ff_wdata   (rcmd_ff_wdata),
    .rtn_vld         (rtn_vld),
    .rtn_last        (rtn_last),
    .rtn_id          (rtn_id),
    .reg_arb_en      (reg_arb_en),
    .reg_arb_mask    (reg_arb_mask),
    .reg_max_ost_cfg (reg_max_ost_cfg),
    .arb_idle        (arb_idle),
    .ost_cnt         (ost_cnt),
    .reg_ost_err     (reg_ost_err)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt [4];
  logic [3:0]  m_err;
  int          m_last;
  int          m_mode;     // 0 run, 1 drain, 2 idle
  logic        m_wen;
  logic [71:0] m_wdata;
  bit          m_valid = 0;

  // Called at the falling edge: compare, then advance to the next rising edge.
  task automatic model_step();
    int lim, win, n;
    logic [3:0]  e_rdy;
    logic [19:0] e_cnt;
    logic [71:0] cmd;
    bit inc, dec, allz;
    lim = (reg_max_ost_cfg == 0) ? 16 : int'(reg_max_ost_cfg);
    win = -1;
    if (m_valid && m_mode == 0 && !rcmd_ff_full && !areset) begin
      for (int k = 1; k <= 4; k++) begin
        n = (m_last + k) % 4;
        if (win < 0 && req_vld[n] && !reg_arb_mask[n] && m_cnt[n] < lim) win = n;
      end
    end
    e_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    chk("m_req_rdy", {68'd0, req_rdy}, {68'd0, e_rdy});
    if (m_valid) begin
      for (int i = 0; i < 4; i++) e_cnt[i*5 +: 5] = m_cnt[i][4:0];
      chk("m_arb_idle", {71'd0, arb_idle}, {71'd0, m_mode == 2});
      chk("m_wen", {71'd0, rcmd_ff_wen}, {71'd0, m_wen});
      chk("m_wdata", rcmd_ff_wdata, m_wdata);
      chk("m_ost_cnt", {52'd0, ost_cnt}, {52'd0, e_cnt});
      chk("m_ost_err", {68'd0, reg_ost_err}, {68'd0, m_err});
    end
    if (areset) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_err = 0; m_last = 3; m_mode = 2; m_wen = 0; m_wdata = 0; m_valid = 1;
    end else if (m_valid) begin
      m_wen = (win >= 0);
      if (win >= 0) begin
        cmd = req_data[win*72 +: 72];
        cmd[35:34] = 2'(win);
        m_wdata = cmd;
        m_last  = win;
      end
      allz = 1;
      for (int i = 0; i < 4; i++) begin
        inc = (win == i);
        dec = rtn_vld && rtn_last && (int'(rtn_id[1:0]) == i);
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc) begin
          if (m_cnt[i] == 0) m_err[i] = 1'b1;
          else m_cnt[i]--;
        end
        if (m_cnt[i] != 0) allz = 0;
      end
      case (m_mode)
        0: if (!reg_arb_en) m_mode = 1;
        1: if (reg_arb_en) m_mode = 0; else if (allz && !m_wen) m_mode = 2;
        default: if (reg_arb_en) m_mode = 0;
      endcase
    end
  endtask

  // Inputs change 1 time unit after a rising edge; directed checks happen
  // 2 units later; the model samples at the falling edge.
  task automatic tick();
    @(negedge aclk);
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    #2;
    chk("rdy_in_reset", {68'd0, req_rdy}, 72'd0);
    tick();
    areset = 1'b0;
  endtask

  initial begin
    int g;
    logic [3:0] eoh;
    logic [3:0] mseq [3];
    areset = 1; req_vld = 0; rcmd_ff_full = 0; rtn_vld = 0; rtn_last = 0;
    rtn_id = 0; reg_arb_en = 1; reg_arb_mask = 0; reg_max_ost_cfg = 0;
    for (int n = 0; n < 4; n++)
      req_data[n*72 +: 72] = {$urandom(), $urandom(), $urandom()};

    // Round-robin over four held requests
    req_vld = 4'hF;
    do_reset();
    #2;
    chk("idle_after_reset", {71'd0, arb_idle}, 72'd1);
    chk("wdata_after_reset", rcmd_ff_wdata, 72'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #2;
      eoh = 4'b0001 << (i % 4);
      chk("rr_rdy", {68'd0, req_rdy}, {68'd0, eoh});
      if (i > 0) begin
        chk("rr_wen", {71'd0, rcmd_ff_wen}, 72'd1);
        chk("rr_wid", {70'd0, rcmd_ff_wdata[35:34]}, 72'((i - 1) % 4));
      end
      tick();
    end
    #2;
    chk("rr_wid_last", {70'd0, rcmd_ff_wdata[35:34]}, 72'd0);
    req_vld = 0;
    tick();

    // Outstanding limit of 2 on requester 1
    reg_max_ost_cfg = 4'd2; req_vld = 4'b0010;
    do_reset();
    tick();
    g = 0;
    for (int i = 0; i < 6; i++) begin #2; if (req_rdy[1]) g++; tick(); end
    #2;
    chk("lim_grants", 72'(g), 72'd2);
    chk("lim_cnt1", {67'd0, ost_cnt[9:5]}, 72'd2);
    rtn_vld = 1; rtn_last = 1; rtn_id = 4'h5;
    tick();
    rtn_vld = 0; rtn_last = 0;
    g = 0;
    for (int i = 0; i < 4; i++) begin #2; if (req_rdy[1]) g++; tick(); end
    chk("lim_regrant", 72'(g), 72'd1);
    req_vld = 0; reg_max_ost_cfg = 0;

    // Downstream full blocks everything
    req_vld = 4'hF; rcmd_ff_full = 1;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("full_rdy", {68'd0, req_rdy}, 72'd0);
      chk("full_wen", {71'd0, rcmd_ff_wen}, 72'd0);
      tick();
    end
    rcmd_ff_full = 0;
    #2;
    chk("unfull_rdy", {68'd0, req_rdy}, 72'd1);
    tick();
    #2;
    chk("unfull_wen", {71'd0, rcmd_ff_wen}, 72'd1);
    req_vld = 0;

    // Masked requesters 0 and 2
    reg_arb_mask = 4'b0101; req_vld = 4'hF;
    do_reset();
    tick();
    mseq[0] = 4'b0010; mseq[1] = 4'b1000; mseq[2] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("mask_rdy", {68'd0, req_rdy}, {68'd0, mseq[i]});
      tick();
    end
    req_vld = 0; reg_arb_mask = 0;

    // Simultaneous grant and completion on requester 2
    req_vld = 4'b0100;
    do_reset();
    tick(); tick(); tick(); tick();
    rtn_vld = 1; rtn_last = 1; rtn_id = 4'h2;
    #2;
    chk("same_cnt2_pre", {67'd0, ost_cnt[14:10]}, 72'd3);
    chk("same_rdy", {68'd0, req_rdy}, 72'd4);
    tick();
    rtn_vld = 0; rtn_last = 0; req_vld = 0;
    #2;
    chk("same_cnt2_post", {67'd0, ost_cnt[14:10]}, 72'd3);

    // Underflow on requester 3 (upper rid bits set)
    rtn_vld = 1; rtn_last = 1; rtn_id = 4'hF;
    tick();
    rtn_vld = 0; rtn_last = 0;
    #2;
    chk("uf_cnt3", {67'd0, ost_cnt[19:15]}, 72'd0);
    chk("uf_err", {68'd0, reg_ost_err}, 72'h8);
    tick(); tick(); tick();
    #2;
    chk("uf_sticky", {68'd0, reg_ost_err}, 72'h8);
    do_reset();
    #2;
    chk("uf_cleared", {68'd0, reg_ost_err}, 72'd0);

    // Drain with two outstanding on requester 0
    req_vld = 4'b0001;
    tick(); tick(); tick();
    req_vld = 0; reg_arb_en = 0;
    tick();
    req_vld = 4'hF;
    #2;
    chk("drain_rdy", {68'd0, req_rdy}, 72'd0);
    chk("drain_busy", {71'd0, arb_idle}, 72'd0);
    chk("drain_cnt0", {67'd0, ost_cnt[4:0]}, 72'd2);
    tick(); tick();
    rtn_vld = 1; rtn_last = 1; rtn_id = 4'h0;
    tick();
    rtn_vld = 0;
    tick();
    rtn_vld = 1;
    #2;
    chk("drain_busy2", {71'd0, arb_idle}, 72'd0);
    tick();
    rtn_vld = 0; rtn_last = 0;
    #2;
    chk("drain_idle", {71'd0, arb_idle}, 72'd1);
    chk("drain_cnt0_0", {67'd0, ost_cnt[4:0]}, 72'd0);
    tick();
    reg_arb_en = 1;
    tick();
    #2;
    chk("resume_rdy", {68'd0, req_rdy}, 72'd2);
    tick();
    req_vld = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4m_rd_arb.md
AXI4M_RD_ARB -- requirements
Module: axi4m_rd_arb

Interface
REQ-001 The block SHALL have parameter REQ_NUM, default 4, meaning the number of read-command requesters (fixed at 4; id field is 2 bits).
REQ-002 The block SHALL have parameter CMD_W, default 72, meaning the read-command word width.
REQ-003 The block SHALL have parameter OST_W, default 5, meaning the per-requester outstanding-counter width.
REQ-004 The block SHALL use one clock, aclk, and a synchronous, active-high reset, areset.
REQ-005 Ports SHALL be as follows, with clock and reset first:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- req_vld  in  4  per-requester command valid
- req_data  in  288  4x72 commands; requester n occupies bits [72n+71:72n]
- req_rdy  out  4  one-hot grant/accept, combinational
- rcmd_ff_full  in  1  downstream command FIFO almost-full
- rcmd_ff_wen  out  1  downstream write strobe, registered
- rcmd_ff_wdata  out  72  downstream command, registered
- rtn_vld  in  1  read data beat accepted (rvalid&rready)
- rtn_last  in  1  beat is rlast
- rtn_id  in  4  rid of beat
- reg_arb_en  in  1  1 = arbitrate; 0 = stop and drain
- reg_arb_mask  in  4  1 = requester n disabled
- reg_max_ost_cfg  in  4  max outstanding bursts per requester; 0 means 16
- arb_idle  out  1  drained, nothing outstanding
- ost_cnt  out  20  4x5 outstanding counters; requester n at bits [5n+4:5n]
- reg_ost_err  out  4  sticky underflow flag per requester

Function
REQ-006 Command format SHALL be: [33:0] address, [35:34] id, [41:36] byte remainder, [49:42] 64B length; all other bits pass through.
REQ-007 The eligible set SHALL be req_vld & ~reg_arb_mask & (ost_cnt[n] < limit), where limit = reg_max_ost_cfg, or 16 when the configuration is 0.
REQ-008 A grant SHALL occur in a cycle when state==RUN, eligible!=0 and rcmd_ff_full==0; req_rdy SHALL then be one-hot to the winner, and SHALL be all-zero otherwise.
REQ-009 Winner SHALL be round-robin, searching upward from last_grant+1 modulo 4; last_grant SHALL be updated only on a grant.
REQ-010 At most one grant SHALL occur per cycle; back-to-back grants on consecutive cycles SHALL be allowed.
REQ-011 One cycle after a grant, rcmd_ff_wen=1 and rcmd_ff_wdata = the winner's req_data with [35:34] overwritten by the winner index; otherwise rcmd_ff_wen=0 and rcmd_ff_wdata holds its value.
REQ-012 ost_cnt[n] SHALL increment on a grant to n.
REQ-013 ost_cnt[n] SHALL decrement on rtn_vld&rtn_last with rtn_id[1:0]==n; rtn_id[3:2] SHALL be ignored.
REQ-014 A simultaneous increment and decrement on the same n SHALL leave ost_cnt[n] unchanged.
REQ-015 A decrement with ost_cnt[n]==0 SHALL saturate at 0 and set reg_ost_err[n]; reg_ost_err SHALL clear only on reset.
REQ-016 FSM states SHALL be RUN, DRAIN and IDLE.
- RUN -> DRAIN when reg_arb_en==0.
- DRAIN -> IDLE when all ost_cnt==0 and no write is pending.
- DRAIN -> RUN when reg_arb_en returns to 1.
- IDLE -> RUN when reg_arb_en==1.
REQ-017 No grants SHALL be issued in DRAIN or IDLE; return beats SHALL still be counted in every state.
REQ-018 arb_idle SHALL be 1 only in state IDLE.
REQ-019 A change to reg_arb_mask or reg_max_ost_cfg SHALL take effect in the next eligibility evaluation; already-issued bursts SHALL be unaffected.
REQ-020 Lowering the limit below the current ost_cnt SHALL block that requester until its count drops below the new limit.

Reset
REQ-021 On areset=1 at a clock edge, the block SHALL set: state=IDLE, last_grant=3 (so requester 0 wins first), all ost_cnt=0, reg_ost_err=0, rcmd_ff_wen=0, rcmd_ff_wdata=0.
REQ-022 req_rdy SHALL be 0 while areset=1.
REQ-023 Reset mid-operation SHALL discard the pending write and all counts, with no completion tracking afterwards.
REQ-024 arb_idle SHALL read 1 in the cycle after reset.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the command field positions (ADDR, ID, REM, LEN) and the OST limit default of 16.
REQ-026 The round-robin picker SHALL be one sub-module, rr_arb4: inputs are the 4-bit request and the last grant; output is the one-hot grant, combinational.

Verification
REQ-027 After reset, reg_arb_en=1 and req_vld=4'b1111 held -> grants 0,1,2,3,0 on consecutive cycles; rcmd_ff_wdata[35:34] = 0,1,2,3,0, one cycle later.
REQ-028 reg_max_ost_cfg=2, only requester 1 valid, no returns -> exactly 2 grants, then req_rdy stays 0 and ost_cnt[1]=2; one rtn_last with rtn_id=1 -> 1 further grant.
REQ-029 rcmd_ff_full=1 with all requests valid -> req_rdy=0 and rcmd_ff_wen=0 for the full duration; deassert full -> a grant on the same cycle.
REQ-030 A grant and an rtn_last for requester 2 in the same cycle, with ost_cnt[2]=3 -> ost_cnt[2] stays 3.
REQ-031 rtn_last with rtn_id=3 while ost_cnt[3]=0 -> ost_cnt[3] stays 0 and reg_ost_err=4'b1000 until reset.
REQ-032 ost_cnt[0]=2 and reg_arb_en dropped -> no further grants, arb_idle=0; two returns for id 0 -> arb_idle=1 the cycle after the second return.
